seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit hex 7-segment driver with a double-buffered value and optional leading-zero blanking.
// Define SEG7_DP_EN to add per-digit decimal-point input dp and output seg_dp.
module seg7_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic                  en,
`ifdef SEG7_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  seg_dp,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [4*DIGITS-1:0] pend_val, act_val, act_val_nxt;
    logic                pend_lz, pend_flag, act_lz, act_lz_nxt;
    logic                pwrap, fwrap, xfer;
    logic [3:0]          nib;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
    logic                seg_dp_nxt;
`endif

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // A digit is a leading zero when it and every more-significant nibble is zero; digit 0 always shows.
    function automatic logic is_blank(input logic [4*DIGITS-1:0] v, input logic [IDX_W-1:0] k);
        logic nonzero;
        nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(k))
                nonzero = nonzero | (v[4*i +: 4] != 4'h0);
        end
        return (k != '0) && !nonzero;
    endfunction

    always_comb begin
        pwrap    = (pcnt == PCNT_W'(CLK_DIV - 1));
        fwrap    = pwrap && (idx == IDX_W'(DIGITS - 1));
        pcnt_nxt = pwrap ? '0 : pcnt + PCNT_W'(1);
        idx_nxt  = idx;
        if (pwrap)
            idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        // Transfer uses pending contents from before this edge, so a same-edge load waits a frame.
        xfer        = fwrap && pend_flag;
        act_val_nxt = xfer ? pend_val : act_val;
        act_lz_nxt  = xfer ? pend_lz : act_lz;
        nib         = act_val_nxt[{idx_nxt, 2'b00} +: 4];
        seg_nxt     = '0;
        an_nxt      = '0;
        if (en) begin
            an_nxt  = DIGITS'(1) << idx_nxt;
            seg_nxt = (act_lz_nxt && is_blank(act_val_nxt, idx_nxt)) ? 7'b0000000 : hex_decode(nib);
        end
`ifdef SEG7_DP_EN
        act_dp_nxt = xfer ? pend_dp : act_dp;
        seg_dp_nxt = en && act_dp_nxt[idx_nxt];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt      <= '0;
            idx       <= '0;
            pend_val  <= '0;
            pend_lz   <= 1'b0;
            pend_flag <= 1'b0;
            act_val   <= '0;
            act_lz    <= 1'b0;
            seg       <= '0;
            an        <= '0;
            frame     <= 1'b0;
`ifdef SEG7_DP_EN
            pend_dp   <= '0;
            act_dp    <= '0;
            seg_dp    <= 1'b0;
`endif
        end else begin
            pcnt    <= pcnt_nxt;
            idx     <= idx_nxt;
            act_val <= act_val_nxt;
            act_lz  <= act_lz_nxt;
            seg     <= seg_nxt;
            an      <= an_nxt;
            frame   <= fwrap;
            if (load) begin
                pend_val  <= value;
                pend_lz   <= blank_lz;
                pend_flag <= 1'b1;
            end else if (xfer) begin
                pend_flag <= 1'b0;
            end
`ifdef SEG7_DP_EN
            if (load)
                pend_dp <= dp;
            act_dp <= act_dp_nxt;
            seg_dp <= seg_dp_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4 (default build).
module tb_seg7_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] value = '0;
    logic                blank_lz = 1'b0;
    logic                en = 1'b1;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                frame;

    int n_vec = 0;
    int n_err = 0;
    int t = 0;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SF = 7'b1000111;
    localparam logic [6:0] SB = 7'b0000000;

    seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
        .en(en), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %0h, expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic fr_e);
        chk($sformatf("%s.an", tag), 32'(an), 32'(an_e));
        chk($sformatf("%s.seg", tag), 32'(seg), 32'(seg_e));
        chk($sformatf("%s.frame", tag), 32'(frame), 32'(fr_e));
    endtask

    // Advance to cycle count target (posedges since reset release), sampling at the next negedge.
    task automatic go_to(input int target);
        while (t < target) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic lz);
        value    = v;
        blank_lz = lz;
        load     = 1'b1;
        go_to(t + 1);
        load     = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_out("rst_hold", 4'b0000, SB, 1'b0);
        rst = 1'b0;
        t = 0;

        go_to(1);  chk_out("scan_t1", 4'b0001, S0, 1'b0);
        go_to(4);  chk_out("scan_t4", 4'b0010, S0, 1'b0);
        go_to(8);  chk_out("scan_t8", 4'b0100, S0, 1'b0);
        go_to(12); chk_out("scan_t12", 4'b1000, S0, 1'b0);
        go_to(15); chk_out("scan_t15", 4'b1000, S0, 1'b0);
        go_to(16); chk_out("wrap_t16", 4'b0001, S0, 1'b1);
        go_to(17); chk_out("post_t17", 4'b0001, S0, 1'b0);

        go_to(18);
        do_load(16'h12AF, 1'b0);
        go_to(31); chk_out("old_t31", 4'b1000, S0, 1'b0);
        go_to(32); chk_out("new_d0", 4'b0001, SF, 1'b1);
        go_to(36); chk_out("new_d1", 4'b0010, SA, 1'b0);
        go_to(40); chk_out("new_d2", 4'b0100, S2, 1'b0);
        go_to(44); chk_out("new_d3", 4'b1000, S1, 1'b0);

        go_to(45);
        do_load(16'h0005, 1'b1);
        go_to(48); chk_out("lz5_d0", 4'b0001, S5, 1'b1);
        go_to(52); chk_out("lz5_d1", 4'b0010, SB, 1'b0);
        go_to(56); chk_out("lz5_d2", 4'b0100, SB, 1'b0);
        go_to(60); chk_out("lz5_d3", 4'b1000, SB, 1'b0);
        do_load(16'h0000, 1'b1);
        go_to(64); chk_out("lz0_d0", 4'b0001, S0, 1'b1);
        go_to(68); chk_out("lz0_d1", 4'b0010, SB, 1'b0);
        go_to(76); chk_out("lz0_d3", 4'b1000, SB, 1'b0);

        go_to(78);
        value = 16'h1111; blank_lz = 1'b0; load = 1'b1;
        go_to(79);
        value = 16'h2222;
        go_to(80);
        load = 1'b0;
        chk_out("same_wrap_d0", 4'b0001, S1, 1'b1);
        go_to(84); chk_out("same_wrap_d1", 4'b0010, S1, 1'b0);
        go_to(95); chk_out("same_wrap_d3", 4'b1000, S1, 1'b0);
        go_to(96); chk_out("next_wrap_d0", 4'b0001, S2, 1'b1);

        go_to(98);
        en = 1'b0;
        go_to(99);  chk_out("en0_t99", 4'b0000, SB, 1'b0);
        go_to(104); chk_out("en0_t104", 4'b0000, SB, 1'b0);
        go_to(108); chk_out("en0_t108", 4'b0000, SB, 1'b0);
        en = 1'b1;
        go_to(109); chk_out("en1_t109", 4'b1000, S2, 1'b0);
        go_to(112); chk_out("en1_wrap", 4'b0001, S2, 1'b1);

        go_to(114);
        do_load(16'h3333, 1'b0);
        go_to(118);
        rst = 1'b1;
        #1;
        chk_out("rst_async", 4'b0000, SB, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("rst_held", 4'b0000, SB, 1'b0);
        rst = 1'b0;
        t = 0;
        go_to(1);  chk_out("rst2_t1", 4'b0001, S0, 1'b0);
        go_to(16); chk_out("rst2_wrap", 4'b0001, S0, 1'b1);
        go_to(20); chk_out("rst2_d1", 4'b0010, S0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
